// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the RV32I load/store unit:
//   - funct3 width/sign codes for loads and stores
//   - 2-bit FSM state encoding (IDLE=0, ACCESS=1, LOAD_WAIT=2, RESP=3)
//   - helper that flags funct3 codes with no RV32I meaning
// -----------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCESS    = 2'd1,
    LOAD_WAIT = 2'd2,
    RESP      = 2'd3
  } lsu_state_t;

  // Stores only have B/H/W; loads additionally have the unsigned BU/HU forms.
  function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
    logic bad;
    if (store) begin
      bad = !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W));
    end else begin
      bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
    return bad;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Combinational extract-and-extend of load data from a 32-bit RAM word.
// Ports:
//   i_word   [31:0] : aligned word returned by memory
//   i_off    [1:0]  : byte offset of the access inside the word
//   i_funct3 [2:0]  : RV32I load width/sign code
//   o_data   [31:0] : sign- or zero-extended load result
// -----------------------------------------------------------------------------
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_off)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

    o_data = 32'h0;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'h0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'h0, w_half};
      F3_W:    o_data = i_word;
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// RV32I load/store engine between the execute stage and a word-wide,
// one-cycle-latency RAM. One request at a time over valid/ready; each request
// produces exactly one single-cycle response pulse.
//
// Optional feature: define LSU_MISALIGN_CHECK_EN to flag misaligned H/HU/W
// accesses as errors. Without it, the halfword offset is forced to addr[1],
// the word offset to 0, and the access proceeds.
//
// Ports:
//   clk, reset_n              : clock, asynchronous active-low reset
//   req_valid/req_ready       : request handshake (ready only in IDLE)
//   req_store, req_funct3     : operation and width/sign code
//   req_addr, req_wdata       : byte address and low-aligned store data
//   rsp_valid/rsp_rdata/rsp_err : one-cycle response, formatted data, error
//   mem_addr, mem_rstrb       : word address and read strobe to RAM
//   mem_rdata                 : RAM read data (valid the cycle after rstrb)
//   mem_wdata, mem_wmask      : lane-replicated store data and byte enables
// -----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rstrb,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask
);

`ifdef LSU_MISALIGN_CHECK_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3)
      F3_H, F3_HU: bad = off[0];
      F3_W:        bad = (off != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction
`endif

  // Byte offset actually used for the lanes. Halfwords can only sit on
  // addr[1] and words on lane 0; this also defines the unchecked behaviour.
  function automatic logic [1:0] lane_off(input logic [2:0] f3, input logic [1:0] off);
    logic [1:0] o;
    case (f3)
      F3_H, F3_HU: o = {off[1], 1'b0};
      F3_W:        o = 2'b00;
      default:     o = off;
    endcase
    return o;
  endfunction

  lsu_state_t        r_state;
  lsu_state_t        w_next;

  logic              r_store;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;
  logic [31:0]       r_wdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;

  logic              w_accept;
  logic              w_req_err;
  logic [31:0]       w_load_data;

  assign w_accept = (r_state == IDLE) && req_valid;

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_req_err = f3_illegal(req_store, req_funct3) ||
                     misaligned(req_funct3, req_addr[1:0]);
`else
  assign w_req_err = f3_illegal(req_store, req_funct3);
`endif

  lsu_load_align u_align (
    .i_word   (mem_rdata),
    .i_off    (r_off),
    .i_funct3 (r_f3),
    .o_data   (w_load_data)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and memory/handshake outputs
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    mem_rstrb = 1'b0;
    mem_wmask = 4'b0000;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next = w_req_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (r_store) begin
          case (r_f3)
            F3_B:    mem_wmask = 4'b0001 << r_off;
            F3_H:    mem_wmask = r_off[1] ? 4'b1100 : 4'b0011;
            F3_W:    mem_wmask = 4'b1111;
            default: mem_wmask = 4'b0000;
          endcase
          w_next = RESP;
        end else begin
          mem_rstrb = 1'b1;
          w_next    = LOAD_WAIT;
        end
      end
      LOAD_WAIT: w_next = RESP;
      RESP:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // Store data is replicated across lanes so the mask alone selects the bytes.
  always_comb begin
    case (r_f3)
      F3_B:    mem_wdata = {4{r_wdata[7:0]}};
      F3_H:    mem_wdata = {2{r_wdata[15:0]}};
      default: mem_wdata = r_wdata;
    endcase
  end

  // Request latch and response registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_store     <= 1'b0;
      r_f3        <= 3'b000;
      r_off       <= 2'b00;
      r_wdata     <= 32'h0;
      r_mem_addr  <= '0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_store     <= req_store;
        r_f3        <= req_funct3;
        r_off       <= lane_off(req_funct3, req_addr[1:0]);
        r_wdata     <= req_wdata;
        r_rsp_rdata <= 32'h0;
        r_rsp_err   <= w_req_err;
        // Rejected requests never touch memory, so the address stays put.
        if (!w_req_err) begin
          r_mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
        end
      end
      if (r_state == LOAD_WAIT) begin
        r_rsp_rdata <= w_load_data;
      end
    end
  end

  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mem_addr  = r_mem_addr;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit with a small behavioural word RAM
// (one-cycle read latency, byte-masked write at the clock edge).
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;

  int n_err = 0;
  int n_chk = 0;

  // Results of the last run_req
  int          t_lat;
  logic        t_rstrb;
  logic [3:0]  t_mask;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic [31:0] t_rdata;
  logic        t_err;

  logic [31:0] ram [0:63] = '{default: 32'h0};

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_rstrb  (mem_rstrb),
    .mem_rdata  (mem_rdata),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask)
  );

  always @(posedge clk) begin
    if (mem_rstrb) mem_rdata <= ram[mem_addr[7:2]];
    for (int b = 0; b < 4; b++) begin
      if (mem_wmask[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request in IDLE, then watch up to 8 cycles for its response.
  // t_lat counts cycles after the accepting edge (0 = no response seen).
  task automatic run_req(input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
    logic got;
    @(negedge clk);
    chk("ready_before_req", {31'h0, req_ready}, 32'd1);
    req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    t_lat = 0; t_rstrb = 1'b0; t_mask = 4'h0; t_addr = 32'h0;
    t_wdata = 32'h0; t_rdata = 32'h0; t_err = 1'b0; got = 1'b0;
    for (int i = 1; i <= 8 && !got; i++) begin
      @(negedge clk);
      if (mem_rstrb) begin
        t_rstrb = 1'b1;
        t_addr  = mem_addr;
      end
      if (mem_wmask != 4'h0) begin
        t_mask  = t_mask | mem_wmask;
        t_addr  = mem_addr;
        t_wdata = mem_wdata;
      end
      if (rsp_valid) begin
        got     = 1'b1;
        t_lat   = i;
        t_rdata = rsp_rdata;
        t_err   = rsp_err;
      end
    end
  endtask

  initial begin
    int p1, p2, np;
    reset_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err",   {31'h0, rsp_err}, 32'd0);
    chk("rst_mem_addr",  mem_addr, 32'h0);
    chk("rst_mem_rstrb", {31'h0, mem_rstrb}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_wmask", {28'h0, mem_wmask}, 32'h0);
    reset_n = 1'b1;

    // ---- SW 0xDEADBEEF @0x10 ----
    run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    chk("sw_lat",   t_lat, 2);
    chk("sw_mask",  {28'h0, t_mask}, 32'hF);
    chk("sw_addr",  t_addr, 32'h10);
    chk("sw_wdata", t_wdata, 32'hDEADBEEF);
    chk("sw_rstrb", {31'h0, t_rstrb}, 32'd0);
    chk("sw_err",   {31'h0, t_err}, 32'd0);
    chk("sw_rdata", t_rdata, 32'h0);

    // ---- LW @0x10 right after the store ----
    run_req(1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw_lat",   t_lat, 3);
    chk("lw_rstrb", {31'h0, t_rstrb}, 32'd1);
    chk("lw_mask",  {28'h0, t_mask}, 32'h0);
    chk("lw_rdata", t_rdata, 32'hDEADBEEF);
    chk("lw_err",   {31'h0, t_err}, 32'd0);

    // ---- SB 0xA5 @0x13 ----
    run_req(1'b1, 3'b000, 32'h13, 32'h000000A5);
    chk("sb_lat",   t_lat, 2);
    chk("sb_addr",  t_addr, 32'h10);
    chk("sb_mask",  {28'h0, t_mask}, 32'h8);
    chk("sb_wdata", t_wdata, 32'hA5A5A5A5);

    run_req(1'b0, 3'b000, 32'h13, 32'h0);
    chk("lb_rdata", t_rdata, 32'hFFFFFFA5);
    run_req(1'b0, 3'b100, 32'h13, 32'h0);
    chk("lbu_rdata", t_rdata, 32'h000000A5);
    run_req(1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw_after_sb", t_rdata, 32'hA5ADBEEF);

    // ---- halfword loads/stores on 0x20 ----
    run_req(1'b1, 3'b010, 32'h20, 32'h80017FFF);
    run_req(1'b0, 3'b001, 32'h22, 32'h0);
    chk("lh_rdata", t_rdata, 32'hFFFF8001);
    run_req(1'b0, 3'b101, 32'h20, 32'h0);
    chk("lhu_rdata", t_rdata, 32'h00007FFF);
    run_req(1'b1, 3'b001, 32'h22, 32'h00001234);
    chk("sh_mask",  {28'h0, t_mask}, 32'hC);
    chk("sh_wdata", t_wdata, 32'h12341234);
    run_req(1'b0, 3'b010, 32'h20, 32'h0);
    chk("lw_after_sh", t_rdata, 32'h12347FFF);

    // ---- misaligned LW @0x21 ----
    run_req(1'b0, 3'b010, 32'h21, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("mis_lat",   t_lat, 1);
    chk("mis_err",   {31'h0, t_err}, 32'd1);
    chk("mis_rstrb", {31'h0, t_rstrb}, 32'd0);
    chk("mis_mask",  {28'h0, t_mask}, 32'h0);
    chk("mis_rdata", t_rdata, 32'h0);
`else
    chk("mis_lat",   t_lat, 3);
    chk("mis_err",   {31'h0, t_err}, 32'd0);
    chk("mis_addr",  t_addr, 32'h20);
    chk("mis_rdata", t_rdata, 32'h12347FFF);
`endif

    // ---- illegal funct3 ----
    run_req(1'b0, 3'b011, 32'h10, 32'h0);
    chk("ill_ld_lat",   t_lat, 1);
    chk("ill_ld_err",   {31'h0, t_err}, 32'd1);
    chk("ill_ld_rstrb", {31'h0, t_rstrb}, 32'd0);
    run_req(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF);
    chk("ill_st_lat",  t_lat, 1);
    chk("ill_st_err",  {31'h0, t_err}, 32'd1);
    chk("ill_st_mask", {28'h0, t_mask}, 32'h0);
    run_req(1'b0, 3'b010, 32'h10, 32'h0);
    chk("ill_st_nowrite", t_rdata, 32'hA5ADBEEF);

    // ---- req_valid held high across two loads ----
    @(negedge clk);
    req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
    p1 = 0; p2 = 0; np = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        np++;
        if (np == 1) p1 = i;
        if (np == 2) p2 = i;
        chk("hold_rdata", rsp_rdata, 32'hA5ADBEEF);
      end
      if (i == 2) chk("hold_busy_ready", {31'h0, req_ready}, 32'd0);
      if (i == 4) chk("hold_idle_ready", {31'h0, req_ready}, 32'd1);
      if (i == 7) req_valid = 1'b0;
    end
    chk("hold_pulses", np, 2);
    chk("hold_first",  p1, 3);
    chk("hold_gap",    p2 - p1, 4);

    // ---- reset during ACCESS of an SW ----
    @(negedge clk);
    req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30;
    req_wdata = 32'h11111111; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_mask_before", {28'h0, mem_wmask}, 32'hF);
    reset_n = 1'b0;
    #1;
    chk("rstmid_mask_after",  {28'h0, mem_wmask}, 32'h0);
    chk("rstmid_rsp_valid",   {31'h0, rsp_valid}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rstmid_no_rsp", {31'h0, rsp_valid}, 32'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rstmid_ready", {31'h0, req_ready}, 32'd1);
      chk("rstmid_idle_rsp", {31'h0, rsp_valid}, 32'd0);
    end
    run_req(1'b0, 3'b010, 32'h30, 32'h0);
    chk("rstmid_nowrite", t_rdata, 32'h0);
    chk("rstmid_lat", t_lat, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
